frame_bank_arbiter: RTL and testbench
=====================================

# frame_bank_arbiter

Parametrised frame-buffer bank manager for the DDR frame buffer, supporting 1 to 4 frame banks. It hands the video writer and the scaler-side reader independent bank indices and DDR start addresses. It uses a latest-complete-frame policy, so the reader never sees a partially written frame. It counts dropped frames (overwritten before being read) and repeated frames (re-read because no new frame was ready).

## Interface
Parameters:
- FB_NUM, 3: number of frame banks, 1..4; any other value is an elaboration error.
- MAX_VID_WIDTH, 1920: maximum active pixels per line.
- MAX_VID_HIGHT, 1080: maximum active lines per frame.
- VID_DATA_WIDTH, 16: bits per pixel.
- START_ADDR, 0: DDR byte address of bank 0.
- FRAME_GUARD, 32'h200: guard bytes appended to each bank.
- ADDR_WIDTH, 32: width of the address outputs.

Ports:
- ddr_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- wr_sw  in  1  writer frame-done request, level; its rising edge is the event.
- rd_sw  in  1  reader frame-start request, level; its rising edge is the event.
- clr_cnt  in  1  synchronous clear of both counters.
- wr_sw_ack  out  1  one-cycle pulse: a write switch was processed.
- rd_sw_ack  out  1  one-cycle pulse: a read switch was processed.
- wr_bank  out  2  bank currently owned by the writer.
- rd_bank  out  2  bank currently owned by the reader.
- wr_start_addr  out  ADDR_WIDTH  base address of wr_bank.
- rd_start_addr  out  ADDR_WIDTH  base address of rd_bank.
- frame_valid  out  1  a completed, unread frame is waiting.
- drop_cnt  out  16  saturating count of dropped frames.
- repeat_cnt  out  16  saturating count of repeated frames.

## Operation
- Address map:
  - FRAME_LEN = MAX_VID_WIDTH*MAX_VID_HIGHT*VID_DATA_WIDTH/8 + FRAME_GUARD.
  - Bank i base = START_ADDR + i*FRAME_LEN, computed as a constant and truncated to ADDR_WIDTH.
  - The *_start_addr outputs always equal the base of the matching *_bank.
- Edge detect: wr_sw_d1 and rd_sw_d1 reset to 1, so a request held high through reset release is not an event. An event is a cycle where sw=1 and sw_d1=0.
- FB_NUM=1:
  - Both banks are fixed at 0.
  - Each event acks on the next edge.
  - frame_valid=0; the counters never increment.
- FB_NUM=2, rendezvous swap:
  - An event without its partner sets wr_pend or rd_pend; its ack is deferred.
  - A swap fires when (wr_pend|wr_evt)&(rd_pend|rd_evt). On a swap, the banks exchange, both acks pulse, and both pends clear.
  - A wr event while wr_pend=1 increments drop_cnt and is otherwise ignored. A rd event while rd_pend=1 increments repeat_cnt and is otherwise ignored.
  - frame_valid = wr_pend.
- FB_NUM=3..4, per-bank state FREE / WRITING / READY / READING; at most one bank is READY.
  - Write event:
    - The WRITING bank becomes READY.
    - A previous READY bank becomes FREE and drop_cnt increments.
    - The writer takes the lowest-index FREE bank, evaluated after the read update of the same cycle.
  - Read event with a READY bank present: the READING bank becomes FREE and the READY bank becomes READING.
  - Read event with no READY bank: the banks are unchanged and repeat_cnt increments.
  - Simultaneous write and read events: the write is resolved first, so the reader receives the frame completed in that same cycle. No drop is counted unless an older READY bank existed.
  - frame_valid = (a READY bank exists).
- Counters saturate at 16'hFFFF. clr_cnt has priority over increment in the same cycle.

## Timing
- Reset values:
  - Banks: wr_bank=0 (WRITING), rd_bank=1 (READING), all other banks FREE; for FB_NUM=1, rd_bank=0.
  - Addresses: wr_start_addr=START_ADDR, rd_start_addr = base of rd_bank.
  - Flags and counters: acks=0, frame_valid=0, pends=0, counters=0.
- Latency: bank, address, ack, flag and counter outputs are all registered. They update on the same ddr_clk edge that first samples sw=1 after sw=0, so the event cycle's outputs are visible one cycle later.
- Acks are exactly one cycle wide. A request held high generates no further events until it returns low.
- Reset asserted mid-operation returns all state to the reset values immediately; no ack fires from a request pending when reset asserts.
- The block never has wr_bank == rd_bank when FB_NUM ≥ 2.

## Test plan
- Reset, FB_NUM=3, default parameters:
  - Required: wr_bank=0 at 0x0, rd_bank=1 at 0x3F4A00, frame_valid=0, counters=0.
  - A wr_sw held high across reset release must not produce an ack.
- FB_NUM=3, wr event, then rd event 5 cycles later:
  - After the wr event: wr_bank=2 at 0x7E9400, frame_valid=1.
  - After the rd event: rd_bank=0, frame_valid=0. Each ack is one cycle wide.
- FB_NUM=3, two wr events then one rd event:
  - Required: drop_cnt=1, the reader gets the second frame's bank, and wr_bank is never equal to rd_bank.
- FB_NUM=3, rd event with no READY bank:
  - Required: rd_bank unchanged, repeat_cnt=1, rd_sw_ack pulses.
  - Then clr_cnt together with another repeat: repeat_cnt=0.
- FB_NUM=3, wr and rd events in the same cycle from reset:
  - Required: rd_bank=0, wr_bank=1, drop_cnt=0, both acks pulse in the same cycle.
- FB_NUM=2, wr event then rd event 10 cycles later:
  - Required: no ack until the rd event, then both acks pulse together and the banks swap (wr=1, rd=0).
  - Then assert rst with wr_pend set: the outputs return to reset values and no ack is generated.

Source files
------------

// File: rtl/frame_bank_arbiter.sv
`default_nettype none
// ==========================================================================
// frame_bank_arbiter : DDR frame-buffer bank manager (1..4 banks)
// Rev 1.0
// ==========================================================================
module frame_bank_arbiter #(
  parameter int                FB_NUM         = 3,
  parameter int                MAX_VID_WIDTH  = 1920,
  parameter int                MAX_VID_HIGHT  = 1080,
  parameter int                VID_DATA_WIDTH = 16,
  parameter logic [63:0]       START_ADDR     = 64'd0,
  parameter logic [63:0]       FRAME_GUARD    = 64'h200,
  parameter int                ADDR_WIDTH     = 32
) (
  input  logic                  ddr_clk,
  input  logic                  rst,
  input  logic                  wr_sw,
  input  logic                  rd_sw,
  input  logic                  clr_cnt,
  output logic                  wr_sw_ack,
  output logic                  rd_sw_ack,
  output logic [1:0]            wr_bank,
  output logic [1:0]            rd_bank,
  output logic [ADDR_WIDTH-1:0] wr_start_addr,
  output logic [ADDR_WIDTH-1:0] rd_start_addr,
  output logic                  frame_valid,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           repeat_cnt
);

  localparam logic [63:0] FRAME_LEN = 64'(MAX_VID_WIDTH) * 64'(MAX_VID_HIGHT)
                                    * 64'(VID_DATA_WIDTH) / 64'd8 + FRAME_GUARD;
  localparam logic [1:0]  RD_RST    = (FB_NUM == 1) ? 2'd0 : 2'd1;

  if (FB_NUM < 1 || FB_NUM > 4) begin : g_bad_fb_num
    $error("frame_bank_arbiter: FB_NUM must be in 1..4");
  end

  function automatic logic [ADDR_WIDTH-1:0] bank_base(input logic [1:0] b);
    logic [63:0] base;
    base = START_ADDR + 64'(b) * FRAME_LEN;
    return base[ADDR_WIDTH-1:0];
  endfunction

  logic                  wr_sw_d1_q, rd_sw_d1_q;
  logic [1:0]            wr_bank_q, wr_bank_d;
  logic [1:0]            rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  rdy_vld_q, rdy_vld_d;
  logic [1:0]            rdy_bank_q, rdy_bank_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [15:0]           drop_q, repeat_q;
  logic                  wr_evt, rd_evt, drop_inc, repeat_inc;

  assign wr_evt = wr_sw & ~wr_sw_d1_q;
  assign rd_evt = rd_sw & ~rd_sw_d1_q;

  // For 3..4 banks the writer/reader/ready indices encode the per-bank state;
  // any bank not referenced by them is FREE.
  always_comb begin
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    rdy_vld_d     = rdy_vld_q;
    rdy_bank_d    = rdy_bank_q;
    wr_pend_d     = wr_pend_q;
    rd_pend_d     = rd_pend_q;
    wr_ack_d      = 1'b0;
    rd_ack_d      = 1'b0;
    frame_valid_d = 1'b0;
    drop_inc      = 1'b0;
    repeat_inc    = 1'b0;
    if (FB_NUM == 1) begin
      wr_ack_d = wr_evt;
      rd_ack_d = rd_evt;
    end else if (FB_NUM == 2) begin
      drop_inc   = wr_evt & wr_pend_q;
      repeat_inc = rd_evt & rd_pend_q;
      if ((wr_pend_q | wr_evt) & (rd_pend_q | rd_evt)) begin
        wr_bank_d = rd_bank_q;
        rd_bank_d = wr_bank_q;
        wr_ack_d  = 1'b1;
        rd_ack_d  = 1'b1;
        wr_pend_d = 1'b0;
        rd_pend_d = 1'b0;
      end else begin
        wr_pend_d = wr_pend_q | wr_evt;
        rd_pend_d = rd_pend_q | rd_evt;
      end
      frame_valid_d = wr_pend_d;
    end else begin
      // Write completion first so a same-cycle read gets the fresh frame.
      if (wr_evt) begin
        drop_inc   = rdy_vld_q;
        rdy_vld_d  = 1'b1;
        rdy_bank_d = wr_bank_q;
      end
      if (rd_evt) begin
        if (rdy_vld_d) begin
          rd_bank_d = rdy_bank_d;
          rdy_vld_d = 1'b0;
        end else begin
          repeat_inc = 1'b1;
        end
      end
      if (wr_evt) begin
        for (int i = FB_NUM - 1; i >= 0; i--) begin
          if (2'(i) != rd_bank_d && !(rdy_vld_d && 2'(i) == rdy_bank_d))
            wr_bank_d = 2'(i);
        end
      end
      wr_ack_d      = wr_evt;
      rd_ack_d      = rd_evt;
      frame_valid_d = rdy_vld_d;
    end
  end

  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      wr_sw_d1_q    <= 1'b1;
      rd_sw_d1_q    <= 1'b1;
      wr_bank_q     <= 2'd0;
      rd_bank_q     <= RD_RST;
      wr_addr_q     <= bank_base(2'd0);
      rd_addr_q     <= bank_base(RD_RST);
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      rdy_vld_q     <= 1'b0;
      rdy_bank_q    <= 2'd0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
    end else begin
      wr_sw_d1_q    <= wr_sw;
      rd_sw_d1_q    <= rd_sw;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_addr_q     <= bank_base(wr_bank_d);
      rd_addr_q     <= bank_base(rd_bank_d);
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      frame_valid_q <= frame_valid_d;
      rdy_vld_q     <= rdy_vld_d;
      rdy_bank_q    <= rdy_bank_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

  // Saturating counters; clear wins over increment.
  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      drop_q   <= 16'd0;
      repeat_q <= 16'd0;
    end else if (clr_cnt) begin
      drop_q   <= 16'd0;
      repeat_q <= 16'd0;
    end else begin
      if (drop_inc && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      if (repeat_inc && repeat_q != 16'hFFFF)
        repeat_q <= repeat_q + 16'd1;
    end
  end

  assign wr_sw_ack     = wr_ack_q;
  assign rd_sw_ack     = rd_ack_q;
  assign wr_bank       = wr_bank_q;
  assign rd_bank       = rd_bank_q;
  assign wr_start_addr = wr_addr_q;
  assign rd_start_addr = rd_addr_q;
  assign frame_valid   = frame_valid_q;
  assign drop_cnt      = drop_q;
  assign repeat_cnt    = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_bank_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_frame_bank_arbiter : directed checks for 3-bank and 2-bank instances
// Rev 1.0
// ==========================================================================
module tb_frame_bank_arbiter;

  logic clk;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 3-bank instance
  logic        a_rst, a_wr, a_rd, a_clr;
  logic        a_wr_ack, a_rd_ack, a_fv;
  logic [1:0]  a_wr_bank, a_rd_bank;
  logic [31:0] a_wr_addr, a_rd_addr;
  logic [15:0] a_drop, a_rep;

  frame_bank_arbiter #(.FB_NUM(3)) u_dut3 (
    .ddr_clk(clk), .rst(a_rst), .wr_sw(a_wr), .rd_sw(a_rd), .clr_cnt(a_clr),
    .wr_sw_ack(a_wr_ack), .rd_sw_ack(a_rd_ack),
    .wr_bank(a_wr_bank), .rd_bank(a_rd_bank),
    .wr_start_addr(a_wr_addr), .rd_start_addr(a_rd_addr),
    .frame_valid(a_fv), .drop_cnt(a_drop), .repeat_cnt(a_rep)
  );

  // 2-bank instance
  logic        b_rst, b_wr, b_rd, b_clr;
  logic        b_wr_ack, b_rd_ack, b_fv;
  logic [1:0]  b_wr_bank, b_rd_bank;
  logic [31:0] b_wr_addr, b_rd_addr;
  logic [15:0] b_drop, b_rep;

  frame_bank_arbiter #(.FB_NUM(2)) u_dut2 (
    .ddr_clk(clk), .rst(b_rst), .wr_sw(b_wr), .rd_sw(b_rd), .clr_cnt(b_clr),
    .wr_sw_ack(b_wr_ack), .rd_sw_ack(b_rd_ack),
    .wr_bank(b_wr_bank), .rd_bank(b_rd_bank),
    .wr_start_addr(b_wr_addr), .rd_start_addr(b_rd_addr),
    .frame_valid(b_fv), .drop_cnt(b_drop), .repeat_cnt(b_rep)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b1; a_wr = 1'b1; a_rd = 1'b0; a_clr = 1'b0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
    nclk(2);

    // ---- 3 banks: reset state, write request held through release ----
    a_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nclk(1);
      chk("a_hold_no_ack", a_wr_ack, 0);
    end
    chk("a_rst_wr_bank", a_wr_bank, 0);
    chk("a_rst_wr_addr", a_wr_addr, 32'h0);
    chk("a_rst_rd_bank", a_rd_bank, 1);
    chk("a_rst_rd_addr", a_rd_addr, 32'h003F_4A00);
    chk("a_rst_fv", a_fv, 0);
    chk("a_rst_drop", a_drop, 0);
    chk("a_rst_rep", a_rep, 0);
    a_wr = 1'b0;
    nclk(1);

    // ---- write then read 5 cycles later ----
    a_wr = 1'b1;
    nclk(1);
    chk("a_w1_ack", a_wr_ack, 1);
    chk("a_w1_wr_bank", a_wr_bank, 2);
    chk("a_w1_wr_addr", a_wr_addr, 32'h007E_9400);
    chk("a_w1_rd_bank", a_rd_bank, 1);
    chk("a_w1_fv", a_fv, 1);
    a_wr = 1'b0;
    nclk(1);
    chk("a_w1_ack_width", a_wr_ack, 0);
    nclk(3);
    a_rd = 1'b1;
    nclk(1);
    chk("a_r1_ack", a_rd_ack, 1);
    chk("a_r1_rd_bank", a_rd_bank, 0);
    chk("a_r1_rd_addr", a_rd_addr, 32'h0);
    chk("a_r1_wr_bank", a_wr_bank, 2);
    chk("a_r1_fv", a_fv, 0);
    a_rd = 1'b0;
    nclk(1);
    chk("a_r1_ack_width", a_rd_ack, 0);

    // ---- two writes then one read: first frame dropped ----
    a_wr = 1'b1;
    nclk(1);
    chk("a_w2_wr_bank", a_wr_bank, 1);
    chk("a_w2_neq", a_wr_bank == a_rd_bank, 0);
    a_wr = 1'b0;
    nclk(1);
    a_wr = 1'b1;
    nclk(1);
    chk("a_w3_wr_bank", a_wr_bank, 2);
    chk("a_w3_drop", a_drop, 1);
    chk("a_w3_fv", a_fv, 1);
    chk("a_w3_neq", a_wr_bank == a_rd_bank, 0);
    a_wr = 1'b0;
    nclk(1);
    a_rd = 1'b1;
    nclk(1);
    chk("a_r2_rd_bank", a_rd_bank, 1);
    chk("a_r2_wr_bank", a_wr_bank, 2);
    chk("a_r2_fv", a_fv, 0);
    chk("a_r2_drop", a_drop, 1);
    a_rd = 1'b0;
    nclk(1);

    // ---- read with nothing ready: repeat, then clear during repeat ----
    a_rd = 1'b1;
    nclk(1);
    chk("a_rep_ack", a_rd_ack, 1);
    chk("a_rep_rd_bank", a_rd_bank, 1);
    chk("a_rep_cnt", a_rep, 1);
    a_rd = 1'b0;
    nclk(1);
    a_rd = 1'b1; a_clr = 1'b1;
    nclk(1);
    chk("a_clr_rep", a_rep, 0);
    chk("a_clr_drop", a_drop, 0);
    chk("a_clr_ack", a_rd_ack, 1);
    a_rd = 1'b0; a_clr = 1'b0;
    nclk(1);
    chk("a_clr_rep_hold", a_rep, 0);

    // ---- simultaneous write and read from reset ----
    a_rst = 1'b1;
    nclk(1);
    chk("a_rst2_wr_bank", a_wr_bank, 0);
    chk("a_rst2_rd_bank", a_rd_bank, 1);
    a_rst = 1'b0;
    nclk(1);
    a_wr = 1'b1; a_rd = 1'b1;
    nclk(1);
    chk("a_sim_wr_ack", a_wr_ack, 1);
    chk("a_sim_rd_ack", a_rd_ack, 1);
    chk("a_sim_rd_bank", a_rd_bank, 0);
    chk("a_sim_wr_bank", a_wr_bank, 1);
    chk("a_sim_wr_addr", a_wr_addr, 32'h003F_4A00);
    chk("a_sim_drop", a_drop, 0);
    chk("a_sim_fv", a_fv, 0);
    a_wr = 1'b0; a_rd = 1'b0;
    nclk(1);
    chk("a_sim_acks_low", {a_wr_ack, a_rd_ack}, 0);

    // ---- 2 banks: rendezvous swap ----
    b_rst = 1'b0;
    nclk(1);
    chk("b_rst_wr_bank", b_wr_bank, 0);
    chk("b_rst_rd_bank", b_rd_bank, 1);
    b_wr = 1'b1;
    nclk(1);
    chk("b_pend_acks", {b_wr_ack, b_rd_ack}, 0);
    chk("b_pend_fv", b_fv, 1);
    b_wr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      nclk(1);
      chk("b_wait_acks", {b_wr_ack, b_rd_ack}, 0);
    end
    b_rd = 1'b1;
    nclk(1);
    chk("b_swap_acks", {b_wr_ack, b_rd_ack}, 2'b11);
    chk("b_swap_wr_bank", b_wr_bank, 1);
    chk("b_swap_rd_bank", b_rd_bank, 0);
    chk("b_swap_wr_addr", b_wr_addr, 32'h003F_4A00);
    chk("b_swap_rd_addr", b_rd_addr, 32'h0);
    chk("b_swap_fv", b_fv, 0);
    b_rd = 1'b0;
    nclk(1);
    chk("b_swap_ack_width", {b_wr_ack, b_rd_ack}, 0);

    // ---- reset with a pending write ----
    b_wr = 1'b1;
    nclk(1);
    chk("b_pend2_fv", b_fv, 1);
    b_wr = 1'b0; b_rd = 1'b1; b_rst = 1'b1;
    nclk(1);
    chk("b_rst3_wr_bank", b_wr_bank, 0);
    chk("b_rst3_rd_bank", b_rd_bank, 1);
    chk("b_rst3_wr_addr", b_wr_addr, 32'h0);
    chk("b_rst3_fv", b_fv, 0);
    chk("b_rst3_acks", {b_wr_ack, b_rd_ack}, 0);
    b_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nclk(1);
      chk("b_post_rst_acks", {b_wr_ack, b_rd_ack}, 0);
    end
    chk("b_post_rst_drop", b_drop, 0);
    b_rd = 1'b0;
    nclk(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
